uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmit byte channel (valid/ready/data into the core TX path) between
//  N_REQ byte-stream requesters. Round-robin packet arbitration: grant held until requester's last
//  byte or MAX_BURST bytes, then rotated. Sits between SW/HW byte producers and the UART TX input.
// PARAMETERS
//  N_REQ     4   number of requesters (2..8)
//  DATA_W    8   byte width of every stream
//  MAX_BURST 16  max bytes per grant before forced rotation (>=1)
// PORTS
//  clk_i        in  1             clock
//  arst_n_i     in  1             reset, asynchronous, active-low
//  req_valid_i  in  N_REQ         per-requester byte valid
//  req_data_i   in  N_REQ*DATA_W  per-requester byte, requester k at [k*DATA_W +: DATA_W]
//  req_last_i   in  N_REQ         qualifies byte as final byte of packet
//  req_ready_o  out N_REQ         per-requester accept
//  tx_valid_o   out 1             byte valid to UART TX
//  tx_data_o    out DATA_W        byte to UART TX
//  tx_ready_i   in  1             UART TX can accept byte
//  grant_o      out N_REQ         one-hot current owner, 0 when idle
//  busy_o       out 1             1 when state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, grant_o=0, tx_valid_o=0, tx_data_o=0, req_ready_o=0, busy_o=0,
//    rr pointer=N_REQ-1 (requester 0 wins first), burst count=0. Reset mid-packet aborts it, no flush.
//  - Transfer = tx_valid_o && tx_ready_i. Requester beat = req_valid_i[k] && req_ready_o[k].
//  - FSM IDLE -> (HDR) -> XFER -> IDLE.
//  - IDLE: if any req_valid_i, pick first valid index searching ptr+1, ptr+2, ... mod N_REQ;
//    register grant, set ptr=winner. Grant visible cycle after valid seen (1-cycle arb latency).
//    No valid: stay IDLE, outputs 0.
//  - XFER (owner g): tx_valid_o=req_valid_i[g], tx_data_o=req_data_i[g],
//    req_ready_o[g]=tx_ready_i (combinational), all other req_ready_o=0.
//  - Owner dropping valid mid-packet: grant held, tx_valid_o=0, no rotation.
//  - Burst count increments per transfer; on transfer with req_last_i[g]=1 OR count==MAX_BURST-1:
//    count<=0, grant<=0, go IDLE. Next arbitration starts at g+1 (fairness even if g still valid).
//  - Simultaneous last and MAX_BURST hit: single release, same as either.
//  - tx_data_o is 0 whenever tx_valid_o=0. tx_valid_o never drops before transfer while owner
//    keeps req_valid_i (stability passes through from requester).
//  - Counter width $clog2(MAX_BURST+1); no wrap possible since release at MAX_BURST-1.
// CONFIGURATION
//  UART_ARB_ID_TAG_EN defined: after IDLE grant, HDR state emits one tag byte
//    tx_data_o = 8'h80 | g (zero-extended to DATA_W), tx_valid_o=1, all req_ready_o=0;
//    on transfer -> XFER. Tag byte does not count toward MAX_BURST. Reset in HDR -> IDLE.
//  Undefined: no HDR state, IDLE -> XFER directly; packet bytes only.
// TESTING
//  1 Reset: arst_n_i low mid-XFER -> all outputs 0 next edge, restart grants requester 0 first.
//  2 Single requester 1 sends 3 bytes 0x41,0x42,0x43(last), tx_ready_i=1 -> tx_data_o sequence
//    41,42,43, grant_o=4'b0010 during packet, busy_o 0 one cycle after last.
//  3 All 4 valid, 1-byte packets each -> grant order 0,1,2,3,0; no requester skipped.
//  4 Req0 streams 20 bytes without last, req2 valid -> 16 bytes from req0, then req2 granted,
//    then req0 resumes with remaining 4.
//  5 tx_ready_i low 5 cycles mid-packet -> tx_data_o/tx_valid_o held, req_ready_o[g]=0, no loss;
//    owner drops valid 3 cycles -> grant held, tx_valid_o=0.
//  6 UART_ARB_ID_TAG_EN: req3 packet 0x55(last) -> tx bytes 0x83 then 0x55; without macro only 0x55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX byte channel among N_REQ byte streams.
// Optional ID tag byte before each packet when UART_ARB_ID_TAG_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    input  logic [N_REQ-1:0]          req_last_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      tx_valid_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_ready_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      busy_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

`ifdef UART_ARB_ID_TAG_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_XFER} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_grant;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_idx;
    logic               w_owner_valid;
    logic               w_owner_last;
    logic [DATA_W-1:0]  w_owner_data;
    logic               w_xfer;
    logic               w_release;

    assign w_owner_valid = req_valid_i[r_owner];
    assign w_owner_last  = req_last_i[r_owner];
    assign w_owner_data  = req_data_i[int'(r_owner) * DATA_W +: DATA_W];
    assign w_xfer        = tx_valid_o && tx_ready_i;
    assign w_release     = w_owner_last || (r_cnt == CNT_W'(MAX_BURST - 1));
    assign grant_o       = r_grant;
    assign busy_o        = (r_state != S_IDLE);

    // Search starts one past the last winner so the previous owner goes last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            w_idx = IDX_W'((int'(r_ptr) + i) % N_REQ);
            if (!w_found && req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
`ifdef UART_ARB_ID_TAG_EN
                    w_state_nxt = S_HDR;
`else
                    w_state_nxt = S_XFER;
`endif
                end
            end
`ifdef UART_ARB_ID_TAG_EN
            S_HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = DATA_W'(8'h80) | DATA_W'(r_owner);
                if (tx_ready_i) w_state_nxt = S_XFER;
            end
`endif
            S_XFER: begin
                tx_valid_o           = w_owner_valid;
                tx_data_o            = w_owner_valid ? w_owner_data : '0;
                req_ready_o[r_owner] = tx_ready_i;
                if (w_xfer && w_release) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= IDX_W'(N_REQ - 1);
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_ptr   <= w_win;
                        r_grant <= N_REQ'(1) << w_win;
                        r_cnt   <= '0;
                    end
                end
                S_XFER: begin
                    if (w_xfer) begin
                        if (w_release) begin
                            r_cnt   <= '0;
                            r_grant <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table plus multi-cycle sequences.
// Honours UART_ARB_ID_TAG_EN so the same bench covers both builds.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        tx_ready, tx_valid, busy;
    logic [7:0]  tx_data;

    int checks = 0;
    int failures = 0;
    int inv_err = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(16)) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
        .tx_ready_i(tx_ready), .grant_o(grant), .busy_o(busy)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        rdy;
        logic        exp_tv;
        logic [7:0]  exp_td;
        logic [3:0]  exp_rr;
        logic [3:0]  exp_g;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    // Producer model: requester k emits k*16+sent[k]; last on final byte or every byte if last_each.
    int   rem[4];
    int   sent[4];
    bit   last_each[4];
    logic [11:0] got[$];
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                           input logic r, input logic tv, input logic [7:0] td,
                           input logic [3:0] rr, input logic [3:0] g, input logic b);
        vec_t x;
        x.valid = v; x.last = l; x.data = d; x.rdy = r;
        x.exp_tv = tv; x.exp_td = td; x.exp_rr = rr; x.exp_g = g; x.exp_busy = b;
        vecs.push_back(x);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            rem[k] = 0; sent[k] = 0; last_each[k] = 1'b0;
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic drive_model(input logic [3:0] hold);
        for (int k = 0; k < 4; k++) begin
            req_valid[k]       = (rem[k] > 0) && !hold[k];
            req_last[k]        = req_valid[k] && (last_each[k] || rem[k] == 1);
            req_data[k*8 +: 8] = 8'(k * 16 + sent[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        clear_model();
        drive_model(4'b0000);
        tx_ready = 1'b1;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic step(input logic rdy, input logic [3:0] hold);
        @(negedge clk);
        drive_model(hold);
        tx_ready = rdy;
        #1;
        if (!tx_valid && tx_data != 8'h00) inv_err++;
        if ((req_ready & ~grant) != 4'b0000) inv_err++;
        if (!$onehot0(grant)) inv_err++;
        if (tx_valid && tx_ready) got.push_back({grant, tx_data});
        for (int k = 0; k < 4; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                sent[k]++;
                rem[k]--;
            end
        end
    endtask

    task automatic exp_tag(input int g);
`ifdef UART_ARB_ID_TAG_EN
        exp_q.push_back({4'(1 << g), 8'(8'h80 | g)});
`endif
    endtask

    task automatic exp_byte(input int g, input logic [7:0] d);
        exp_q.push_back({4'(1 << g), d});
    endtask

    task automatic compare_seq(input string name);
        chk($sformatf("%s.count", name), got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s.byte%0d", name, i), {20'h0, got[i]}, {20'h0, exp_q[i]});
        chk($sformatf("%s.invariants", name), inv_err, 0);
        inv_err = 0;
    endtask

    initial begin
        arst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
        clear_model();

        // Table: single-requester packet with a stall, then a one-byte packet from req3.
        add_row(4'b0010, 4'b0000, 32'h0000_4100, 1, 0, 8'h00, 4'b0000, 4'b0000, 0);
`ifdef UART_ARB_ID_TAG_EN
        add_row(4'b0010, 4'b0000, 32'h0000_4100, 1, 1, 8'h81, 4'b0000, 4'b0010, 1);
`endif
        add_row(4'b0010, 4'b0000, 32'h0000_4100, 1, 1, 8'h41, 4'b0010, 4'b0010, 1);
        add_row(4'b0010, 4'b0000, 32'h0000_4200, 1, 1, 8'h42, 4'b0010, 4'b0010, 1);
        add_row(4'b0010, 4'b0010, 32'h0000_4300, 0, 1, 8'h43, 4'b0000, 4'b0010, 1);
        add_row(4'b0010, 4'b0010, 32'h0000_4300, 1, 1, 8'h43, 4'b0010, 4'b0010, 1);
        add_row(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0);
        add_row(4'b1000, 4'b1000, 32'h5500_0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0);
`ifdef UART_ARB_ID_TAG_EN
        add_row(4'b1000, 4'b1000, 32'h5500_0000, 1, 1, 8'h83, 4'b0000, 4'b1000, 1);
`endif
        add_row(4'b1000, 4'b1000, 32'h5500_0000, 1, 1, 8'h55, 4'b1000, 4'b1000, 1);
        add_row(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset.tx_valid", {31'h0, tx_valid}, 0);
        chk("reset.tx_data", {24'h0, tx_data}, 0);
        chk("reset.req_ready", {28'h0, req_ready}, 0);
        chk("reset.grant", {28'h0, grant}, 0);
        chk("reset.busy", {31'h0, busy}, 0);
        @(negedge clk);
        arst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            req_valid = vecs[i].valid; req_last = vecs[i].last;
            req_data = vecs[i].data; tx_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d.tx_valid", i), {31'h0, tx_valid}, {31'h0, vecs[i].exp_tv});
            chk($sformatf("vec%0d.tx_data", i), {24'h0, tx_data}, {24'h0, vecs[i].exp_td});
            chk($sformatf("vec%0d.req_ready", i), {28'h0, req_ready}, {28'h0, vecs[i].exp_rr});
            chk($sformatf("vec%0d.grant", i), {28'h0, grant}, {28'h0, vecs[i].exp_g});
            chk($sformatf("vec%0d.busy", i), {31'h0, busy}, {31'h0, vecs[i].exp_busy});
        end

        // Reset mid-packet: outputs clear, then requester 0 wins first again.
        do_reset();
        rem[1] = 5;
        repeat (3) step(1, 4'b0000);
`ifdef UART_ARB_ID_TAG_EN
        step(1, 4'b0000);
`endif
        chk("rst_mid.grant_before", {28'h0, grant}, 32'h2);
        @(negedge clk);
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.tx_valid", {31'h0, tx_valid}, 0);
        chk("rst_mid.tx_data", {24'h0, tx_data}, 0);
        chk("rst_mid.req_ready", {28'h0, req_ready}, 0);
        chk("rst_mid.grant", {28'h0, grant}, 0);
        chk("rst_mid.busy", {31'h0, busy}, 0);
        clear_model();
        drive_model(4'b0000);
        @(negedge clk);
        arst_n = 1'b1;
        inv_err = 0;
        rem[0] = 1; rem[1] = 1;
        exp_tag(0); exp_byte(0, 8'h00);
        exp_tag(1); exp_byte(1, 8'h10);
        repeat (8) step(1, 4'b0000);
        compare_seq("rst_restart");

        // All four valid with one-byte packets; requester 0 has a second packet.
        do_reset();
        for (int k = 0; k < 4; k++) begin rem[k] = 1; last_each[k] = 1'b1; end
        rem[0] = 2;
        exp_tag(0); exp_byte(0, 8'h00);
        exp_tag(1); exp_byte(1, 8'h10);
        exp_tag(2); exp_byte(2, 8'h20);
        exp_tag(3); exp_byte(3, 8'h30);
        exp_tag(0); exp_byte(0, 8'h01);
        repeat (20) step(1, 4'b0000);
        compare_seq("round_robin");

        // Long stream from req0 is cut at 16 bytes so req2 gets a turn.
        do_reset();
        rem[0] = 20; rem[2] = 1;
        exp_tag(0);
        for (int i = 0; i < 16; i++) exp_byte(0, 8'(i));
        exp_tag(2); exp_byte(2, 8'h20);
        exp_tag(0);
        for (int i = 16; i < 20; i++) exp_byte(0, 8'(i));
        repeat (32) step(1, 4'b0000);
        compare_seq("max_burst");

        // Sink stall then owner gap: data held during stall, grant held through gap.
        do_reset();
        rem[2] = 4;
        step(1, 4'b0000);
`ifdef UART_ARB_ID_TAG_EN
        step(1, 4'b0000);
`endif
        step(1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b0000);
            chk($sformatf("stall%0d.tx_valid", i), {31'h0, tx_valid}, 1);
            chk($sformatf("stall%0d.tx_data", i), {24'h0, tx_data}, 32'h21);
            chk($sformatf("stall%0d.req_ready", i), {28'h0, req_ready}, 0);
        end
        step(1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b0100);
            chk($sformatf("gap%0d.tx_valid", i), {31'h0, tx_valid}, 0);
            chk($sformatf("gap%0d.grant", i), {28'h0, grant}, 32'h4);
            chk($sformatf("gap%0d.busy", i), {31'h0, busy}, 1);
        end
        step(1, 4'b0000);
        step(1, 4'b0000);
        step(1, 4'b0000);
        chk("stall_end.busy", {31'h0, busy}, 0);
        chk("stall_end.grant", {28'h0, grant}, 0);
        exp_tag(2);
        exp_byte(2, 8'h20); exp_byte(2, 8'h21); exp_byte(2, 8'h22); exp_byte(2, 8'h23);
        compare_seq("stall_gap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
